// File: rtl/nrzi_stuff_enc_pkg.sv
// Shared encoding constants for the USB NRZI/bit-stuff transmit encoder and the
// matching receive-side stuff detector.
package nrzi_stuff_enc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DATA    = 3'd2,
    ST_EOP_SE0 = 3'd3,
    ST_EOP_J   = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;
  localparam logic [1:0] EOP_SE0_BITS = 2'd2;

endpackage

// File: rtl/nrzi_stuff_enc.sv
// USB transmit encoder: byte handshake in, SYNC/stuffing/NRZI/EOP line state out.
// Define NRZI_ENC_SYNC_EN to generate SYNC internally; otherwise the host sends 8'h80 first.
//
// state      | meaning
// ST_IDLE    | line J, driver off, waiting for tx_valid on a sample
// ST_SYNC    | emitting SYNC bits 1..7 (bit 0 goes out on the IDLE exit edge)
// ST_DATA    | serializing bytes LSB-first, stuffing after six 1s
// ST_EOP_SE0 | SE0 for EOP_SE0_BITS bit times
// ST_EOP_J   | one J bit time, then driver off
module nrzi_stuff_enc
  import nrzi_stuff_enc_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       sample,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       line_j,
  output logic       se0,
  output logic       tx_oe,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [2:0] one_cnt_q, one_cnt_d;
  logic [1:0] eop_cnt_q, eop_cnt_d;
  logic       line_j_q, line_j_d;
  logic       se0_q, se0_d;
  logic       tx_oe_q, tx_oe_d;
  logic       ready_raw;
  logic       emit_en;
  logic       emit_bit;
  logic       stuff_now;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    one_cnt_d = one_cnt_q;
    eop_cnt_d = eop_cnt_q;
    line_j_d  = line_j_q;
    se0_d     = se0_q;
    tx_oe_d   = tx_oe_q;
    ready_raw = 1'b0;
    emit_en   = 1'b0;
    emit_bit  = 1'b0;
    stuff_now = (one_cnt_q == STUFF_LIMIT);

    case (state_q)
      ST_IDLE: begin
        if (sample && tx_valid) begin
          tx_oe_d   = 1'b1;
          one_cnt_d = 3'd0;
          emit_en   = 1'b1;
          bit_idx_d = 3'd1;
`ifdef NRZI_ENC_SYNC_EN
          state_d   = ST_SYNC;
          emit_bit  = SYNC_PATTERN[0];
`else
          state_d   = ST_DATA;
          ready_raw = 1'b1;
          emit_bit  = tx_data[0];
          shift_d   = {1'b0, tx_data[7:1]};
`endif
        end
      end
`ifdef NRZI_ENC_SYNC_EN
      ST_SYNC: begin
        if (sample) begin
          emit_en = 1'b1;
          if (stuff_now) begin
            emit_bit = 1'b0;
          end else begin
            emit_bit  = SYNC_PATTERN[bit_idx_q];
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = ST_DATA;
          end
        end
      end
`endif
      ST_DATA: begin
        if (sample) begin
          if (stuff_now) begin
            // Stuffed bit: byte position and shift register hold.
            emit_en  = 1'b1;
            emit_bit = 1'b0;
          end else if (bit_idx_q == 3'd0) begin
            if (tx_valid) begin
              ready_raw = 1'b1;
              emit_en   = 1'b1;
              emit_bit  = tx_data[0];
              shift_d   = {1'b0, tx_data[7:1]};
              bit_idx_d = 3'd1;
            end else begin
              state_d   = ST_EOP_SE0;
              se0_d     = 1'b1;
              line_j_d  = 1'b1;
              eop_cnt_d = EOP_SE0_BITS - 2'd1;
            end
          end else begin
            emit_en   = 1'b1;
            emit_bit  = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_EOP_SE0: begin
        if (sample) begin
          if (eop_cnt_q == 2'd0) begin
            state_d  = ST_EOP_J;
            se0_d    = 1'b0;
            line_j_d = 1'b1;
          end else begin
            eop_cnt_d = eop_cnt_q - 2'd1;
          end
        end
      end
      ST_EOP_J: begin
        if (sample) begin
          state_d   = ST_IDLE;
          tx_oe_d   = 1'b0;
          one_cnt_d = 3'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // NRZI: a 0 toggles the line and breaks the run of 1s.
    if (emit_en) begin
      if (!emit_bit) begin
        line_j_d  = ~line_j_q;
        one_cnt_d = 3'd0;
      end else begin
        one_cnt_d = one_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      one_cnt_q <= 3'd0;
      eop_cnt_q <= 2'd0;
      line_j_q  <= 1'b1;
      se0_q     <= 1'b0;
      tx_oe_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      one_cnt_q <= one_cnt_d;
      eop_cnt_q <= eop_cnt_d;
      line_j_q  <= line_j_d;
      se0_q     <= se0_d;
      tx_oe_q   <= tx_oe_d;
    end
  end

  // Mask the combinational handshake while reset is held.
  assign tx_ready = ready_raw & RST;
  assign line_j   = line_j_q;
  assign se0      = se0_q;
  assign tx_oe    = tx_oe_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nrzi_stuff_enc.sv
// Scoreboard bench for nrzi_stuff_enc: a reference stuffer/NRZI model fills the
// expected line and handshake queues; the monitor pops them on every sample edge.
module tb_nrzi_stuff_enc;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       sample = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, line_j, se0, tx_oe, busy;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  int         rdy_q[$];
  logic [7:0] host_q[$];
  logic [7:0] pay_q[$];
  logic [3:0] prev;
  int         sidx;
  int         cyc;
  int         div;

  localparam logic [3:0] OUT_IDLE = 4'b0001;  // {busy, tx_oe, se0, line_j}

  nrzi_stuff_enc dut (
    .CLK(CLK), .RST(RST), .sample(sample), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .line_j(line_j), .se0(se0), .tx_oe(tx_oe), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: SYNC + payload, stuff after six 1s, NRZI from J, then EOP.
  task automatic build_model();
    logic [7:0] strm[$];
    logic       line;
    int         cnt;
    int         n;
    int         host_first;
    logic       b;
`ifdef NRZI_ENC_SYNC_EN
    host_first = 1;
`else
    host_first = 0;
`endif
    strm.push_back(8'h80);
    foreach (pay_q[i]) strm.push_back(pay_q[i]);
    host_q.delete();
    for (int j = host_first; j < strm.size(); j++) host_q.push_back(strm[j]);
    line = 1'b1;
    cnt  = 0;
    n    = 0;
    for (int j = 0; j < strm.size(); j++) begin
      for (int k = 0; k < 8; k++) begin
        if (j >= host_first && k == 0) rdy_q.push_back(n);
        b = strm[j][k];
        if (!b) line = ~line;
        exp_q.push_back({3'b110, line});
        n++;
        cnt = b ? cnt + 1 : 0;
        if (cnt == 6) begin
          line = ~line;
          exp_q.push_back({3'b110, line});
          n++;
          cnt = 0;
        end
      end
    end
    exp_q.push_back(4'b1111);
    exp_q.push_back(4'b1111);
    exp_q.push_back(4'b1101);
    exp_q.push_back(OUT_IDLE);
  endtask

  task automatic tick();
    logic       rdy;
    logic [3:0] got;
    @(negedge CLK);
    sample   = (cyc % div == 0);
    cyc++;
    tx_valid = (host_q.size() > 0);
    tx_data  = tx_valid ? host_q[0] : 8'h00;
    #1 rdy = tx_ready;
    if (rdy && !sample) check_eq("ready_without_sample", 32'(rdy), 0);
    @(posedge CLK);
    #1;
    got = {busy, tx_oe, se0, line_j};
    if (sample) begin
      if (rdy) begin
        if (rdy_q.size() == 0) check_eq("ready_extra", 1, 0);
        else check_eq("ready_index", sidx, rdy_q.pop_front());
        if (host_q.size() > 0) void'(host_q.pop_front());
      end
      if (exp_q.size() > 0) begin
        check_eq($sformatf("line[%0d]", sidx), 32'(got), 32'(exp_q.pop_front()));
        sidx++;
      end else begin
        check_eq("idle_out", 32'(got), 32'(OUT_IDLE));
      end
    end else begin
      check_eq("hold_out", 32'(got), 32'(prev));
    end
    prev = got;
  endtask

  task automatic run_packet(input int d, input int stop_at);
    int guard;
    div   = d;
    cyc   = 0;
    sidx  = 0;
    guard = 0;
    build_model();
    while (exp_q.size() > 0 && (stop_at == 0 || sidx < stop_at) && guard < 2000) begin
      tick();
      guard++;
    end
    if (stop_at == 0) begin
      check_eq("packet_done", exp_q.size(), 0);
      check_eq("ready_all_seen", rdy_q.size(), 0);
      check_eq("host_drained", host_q.size(), 0);
      repeat (3) tick();
    end else begin
      check_eq("abort_reached", sidx, stop_at);
    end
  endtask

  initial begin
    div = 1;
    cyc = 0;
    // Reset held with tx_valid asserted: nothing may start or handshake.
    RST = 1'b0; tx_valid = 1'b1; sample = 1'b1; tx_data = 8'h80;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("reset_out", 32'({busy, tx_oe, se0, line_j}), 32'(OUT_IDLE));
    check_eq("reset_ready", 32'(tx_ready), 0);
    @(negedge CLK);
    tx_valid = 1'b0; sample = 1'b0;
    RST = 1'b1;
    prev = OUT_IDLE;

    pay_q = '{8'h00};                run_packet(1, 0);
    pay_q = '{8'hFF};                run_packet(3, 0);
    pay_q = '{8'hFC};                run_packet(1, 0);
    pay_q = '{8'hA5, 8'h3C, 8'h00};  run_packet(2, 0);
    pay_q = '{8'hFF, 8'hFF};         run_packet(1, 0);

    // Abort after data bit 4 of 8'hFF, with the stuff counter at its limit.
    pay_q = '{8'hFF};
    run_packet(1, 13);
    @(negedge CLK);
    tx_valid = 1'b1; sample = 1'b1; tx_data = 8'h80;
    RST = 1'b0;
    #1;
    check_eq("abort_out", 32'({busy, tx_oe, se0, line_j}), 32'(OUT_IDLE));
    check_eq("abort_ready", 32'(tx_ready), 0);
    exp_q.delete(); rdy_q.delete(); host_q.delete();
    repeat (2) @(negedge CLK);
    tx_valid = 1'b0; sample = 1'b0;
    RST = 1'b1;
    prev = OUT_IDLE;

    pay_q = '{8'h00};                run_packet(1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nrzi_stuff_enc.md
# nrzi_stuff_enc

USB transmit-side line encoder. Accepts parallel bytes over a UTMI-style valid/ready handshake and serializes them LSB-first at bit rate. Optionally prepends SYNC, inserts a stuffed 0 after six consecutive 1s, NRZI-encodes the stream onto a J/K line-state output, and terminates each packet with EOP. It is the transmit-side counterpart of the NRZI decoder/unstuffer in the UTMI datapath.

## Interface
- CLK  input  1  system clock.
- RST  input  1  reset, asynchronous, active-low.
- sample  input  1  bit-rate strobe; all bit-level state advances only on CLK edges with sample=1.
- tx_valid  input  1  host has a byte to send; held until accepted; deasserting it at a byte boundary ends the packet.
- tx_data  input  8  byte to transmit; captured when tx_ready=1.
- tx_ready  output  1  one-cycle acceptance pulse; tx_data is captured on this CLK edge.
- line_j  output  1  registered line state: 1=J, 0=K.
- se0  output  1  registered SE0 indication (EOP).
- tx_oe  output  1  registered driver enable; high for the whole packet, SYNC through final J.
- busy  output  1  state != IDLE.

## Operation
- Reset values: line_j=1, se0=0, tx_oe=0, tx_ready=0, busy=0, one_cnt=0, state=IDLE.
- States: IDLE, SYNC (SYNC_EN only), DATA, EOP_SE0, EOP_J.
- NRZI: an emitted 0 toggles line_j; an emitted 1 holds line_j. Stuffed bits are 0, so they toggle.
- Stuffing:
  - one_cnt is 3-bit and counts consecutive emitted 1s across SYNC and DATA.
  - On a sample in SYNC/DATA with one_cnt==6, emit a stuffed 0 and set one_cnt<=0. Bit index and shift register hold, and no byte is captured on that sample.
  - Any emitted 0 clears one_cnt.
- IDLE: on sample && tx_valid, set tx_oe<=1 and go to SYNC. With SYNC_EN off, go straight to DATA, capture the byte on this edge, and drive its bit0.
- SYNC: emit 8'h80 LSB-first (KJKJKJKK from an idle J), then go to DATA.
- DATA:
  - tx_ready is combinational: sample && tx_valid && (byte boundary) && !(one_cnt==6).
  - A byte boundary is the sample that would drive bit0 of a new byte.
  - At a boundary with tx_valid=0, go to EOP_SE0. If one_cnt==6 at that point, the stuffed bit is emitted first and the boundary check repeats on the next sample.
  - tx_valid is ignored between boundaries.
- EOP_SE0: se0=1 and line_j=1 for 2 bit times, then EOP_J.
- EOP_J: line_j=1, se0=0 for 1 bit time. Then tx_oe<=0 and return to IDLE. tx_valid is ignored until IDLE is reached.
- RST asserted mid-packet: all outputs return to reset values immediately, and the packet is abandoned.

## Timing
- All outputs except tx_ready change only on CLK edges with sample=1.
- Packet start with SYNC_EN on:
  - tx_oe and the first SYNC K appear on the first sample edge with tx_valid.
  - Byte 0 is captured (tx_ready) on the 9th sample edge.
- Packet start with SYNC_EN off: capture and bit0 occur on the first sample edge.
- Consecutive tx_ready pulses are 8 samples apart, plus 1 per stuffed bit inside the byte.
- EOP: the last data or stuffed bit is followed by exactly 2 SE0 samples, then 1 J sample, then tx_oe=0 on the next sample edge.
- tx_ready is high for at most one CLK per byte, even when sample stays high for consecutive cycles.

## Configuration
- NRZI_ENC_SYNC_EN defined: the block generates SYNC itself. The first tx_data byte is the PID.
- NRZI_ENC_SYNC_EN undefined: the SYNC state is absent. The host supplies 8'h80 as byte 0; stuffing and NRZI treat it as ordinary data.

## Structure
- Shared package holds:
  - state enum;
  - SYNC_PATTERN=8'h80;
  - STUFF_LIMIT=6;
  - EOP_SE0_BITS=2.
- Single module, no sub-module. The stuff counter and NRZI toggle are small enough to stay inline; the package constants are shared with the decoder's stuff detection.

## Test plan
- Reset: RST low with tx_valid=1 -> line_j=1, se0=0, tx_oe=0, tx_ready=0.
- SYNC_EN, single byte 8'h00 -> line K,J,K,J,K,J,K,K, then 8 toggles J,K,J,K,J,K,J,K, then SE0,SE0,J, then tx_oe=0.
- SYNC_EN, byte 8'hFF -> stuffed toggle after data bit4 (SYNC's final 1 plus 5 ones = 6), 9 data-phase bits total, one_cnt=3 at EOP.
- Byte 8'hFC ending in 6 ones, then tx_valid=0 -> stuffed 0 emitted before the first SE0.
- Back-to-back 8'hA5, 8'h3C, 8'h00 with tx_valid held -> tx_ready pulses exactly 8 samples apart, EOP follows the third byte, and the line matches reference NRZI.
- RST asserted at bit 4 of a byte -> immediate reset values. The next tx_valid starts a fresh SYNC with one_cnt=0.
